// File: rtl/wb_mem_pkg.sv
// ---------------------------------------------------------------------------
// wb_mem_pkg
// Shared definitions for the Wishbone slave memory responder:
//   - FSM state encoding (IDLE=0, WAIT, RTY, ERR, ACK)
//   - default data width / address width
//   - statistics counter widths
// ---------------------------------------------------------------------------
package wb_mem_pkg;

  localparam int DEF_DW     = 64;
  localparam int DEF_AW     = 10;
  localparam int BEAT_CNT_W = 16;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_RTY  = 3'd2,
    ST_ERR  = 3'd3,
    ST_ACK  = 3'd4
  } state_t;

endpackage

// File: rtl/wb_mem_ram.sv
// ---------------------------------------------------------------------------
// wb_mem_ram
// Single-port DW-wide, 2**AW-deep RAM with byte-lane write enables and a
// registered read port. Contents are not reset; only the read register is.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (read register only)
//   i_en     port enable for this cycle (one beat)
//   i_we     1 = write lanes selected by i_sel, 0 = read into o_rdata
//   i_addr   word address
//   i_sel    byte-lane enables
//   i_wdata  write data
//   o_rdata  registered read data
// ---------------------------------------------------------------------------
module wb_mem_ram #(
  parameter  int DW = 64,
  parameter  int AW = 10,
  localparam int SW = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [SW-1:0] i_sel,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_sel[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read data only moves on read beats, so it stays stable across write beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              o_rdata <= '0;
    else if (i_en && !i_we)    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/wb_mem_slave.sv
// ---------------------------------------------------------------------------
// wb_mem_slave
// Wishbone slave memory responder with programmable wait states, linear CAB
// bursts, retry and error injection, and optional beat statistics.
// Optional feature macro: WB_MEM_STATS_EN (beat/err counters; 0 when undefined)
// Ports:
//   wb_clk_i / wb_rst_n_i   clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/cab_i/adr_i/sel_i/dat_i   Wishbone slave inputs
//   wbs_dat_o/ack_o/err_o/rty_o                   Wishbone slave outputs
//   cfg_wait_i     wait states before the first beat of an access
//   cfg_rty_i      leading attempts per cycle answered with rty
//   cfg_err_en_i   enable error injection
//   cfg_err_adr_i  byte address whose word is answered with err
//   beat_cnt_o     acked beats since reset (wraps)
//   err_cnt_o      err terminations since reset (saturates)
//   busy_o         FSM not in IDLE
// ---------------------------------------------------------------------------
module wb_mem_slave
  import wb_mem_pkg::*;
#(
  parameter  int DW = DEF_DW,
  parameter  int AW = DEF_AW,
  localparam int SW = DW / 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic                  wbs_cab_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [SW-1:0]         wbs_sel_i,
  input  logic [DW-1:0]         wbs_dat_i,
  output logic [DW-1:0]         wbs_dat_o,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  input  logic [3:0]            cfg_wait_i,
  input  logic [3:0]            cfg_rty_i,
  input  logic                  cfg_err_en_i,
  input  logic [31:0]           cfg_err_adr_i,
  output logic [BEAT_CNT_W-1:0] beat_cnt_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  output logic                  busy_o
);

  localparam int OB = $clog2(SW);

  state_t        r_state;
  logic          r_ack, r_err, r_rty;
  logic [AW-1:0] r_wptr;
  logic [3:0]    r_wait;
  logic [3:0]    r_rty_cnt;

  logic [AW-1:0] w_idx, w_err_idx, w_next_idx, w_ram_addr;
  logic          w_req, w_rty_go, w_err_hit, w_burst_go, w_addr_ok;
  logic          w_beat, w_err_go;
  logic          w_unused;

  assign w_idx      = wbs_adr_i[AW+OB-1:OB];
  assign w_err_idx  = cfg_err_adr_i[AW+OB-1:OB];
  assign w_next_idx = r_wptr + AW'(1);
  assign w_req      = wbs_cyc_i & wbs_stb_i;
  assign w_rty_go   = (r_rty_cnt < cfg_rty_i);
  assign w_err_hit  = cfg_err_en_i & (w_idx == w_err_idx);
  assign w_burst_go = wbs_cyc_i & wbs_stb_i & wbs_cab_i;
  assign w_addr_ok  = (w_idx == w_next_idx);

  // Beat/err decisions are made on the edge that raises ack/err, so the RAM
  // address must already point at the beat being completed: the live bus
  // index from IDLE, the held pointer from WAIT, the prefetch pointer in ACK.
  always_comb begin
    w_beat     = 1'b0;
    w_err_go   = 1'b0;
    w_ram_addr = r_wptr;
    case (r_state)
      ST_IDLE: begin
        w_ram_addr = w_idx;
        if (w_req && !w_rty_go && !w_err_hit && cfg_wait_i == 4'd0) w_beat = 1'b1;
        if (w_req && !w_rty_go && w_err_hit) w_err_go = 1'b1;
      end
      ST_WAIT: begin
        if (wbs_cyc_i && r_wait == 4'd1) w_beat = 1'b1;
      end
      ST_ACK: begin
        w_ram_addr = w_next_idx;
        if (w_burst_go) begin
          if (w_addr_ok) w_beat   = 1'b1;
          else           w_err_go = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Retry precedence over error match is set by the if/else order in IDLE.
  // The retry count clears whenever cyc is low, so every new cycle restarts
  // retry injection.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= ST_IDLE;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rty     <= 1'b0;
      r_wptr    <= '0;
      r_wait    <= '0;
      r_rty_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rty <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_wptr <= w_idx;
            r_wait <= cfg_wait_i;
            if (w_rty_go) begin
              r_state <= ST_RTY;
              r_rty   <= 1'b1;
            end else if (w_err_hit) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else if (cfg_wait_i != 4'd0) begin
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!wbs_cyc_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_wait <= r_wait - 4'd1;
            if (r_wait == 4'd1) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end
          end
        end
        ST_RTY: begin
          r_state   <= ST_IDLE;
          r_rty_cnt <= r_rty_cnt + 4'd1;
        end
        ST_ERR: r_state <= ST_IDLE;
        ST_ACK: begin
          if (w_burst_go) begin
            if (w_addr_ok) begin
              r_wptr <= w_next_idx;
              r_ack  <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (!wbs_cyc_i) r_rty_cnt <= '0;
    end
  end

  // Write enable is gated by reset so a bus request held during reset
  // never reaches the array.
  wb_mem_ram #(.DW(DW), .AW(AW)) u_ram (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n_i),
    .i_en    (w_beat & wb_rst_n_i),
    .i_we    (wbs_we_i),
    .i_addr  (w_ram_addr),
    .i_sel   (wbs_sel_i),
    .i_wdata (wbs_dat_i),
    .o_rdata (wbs_dat_o)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbs_rty_o = r_rty;
  assign busy_o    = (r_state != ST_IDLE);

`ifdef WB_MEM_STATS_EN
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_beat) r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
      if (w_err_go && r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign beat_cnt_o = r_beat_cnt;
  assign err_cnt_o  = r_err_cnt;
  assign w_unused   = ^{wbs_adr_i[31:AW+OB], wbs_adr_i[OB-1:0],
                        cfg_err_adr_i[31:AW+OB], cfg_err_adr_i[OB-1:0]};
`else
  assign beat_cnt_o = '0;
  assign err_cnt_o  = '0;
  assign w_unused   = ^{wbs_adr_i[31:AW+OB], wbs_adr_i[OB-1:0],
                        cfg_err_adr_i[31:AW+OB], cfg_err_adr_i[OB-1:0], w_err_go};
`endif

endmodule

// File: tb/tb_wb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_mem_slave
// Directed bench for wb_mem_slave (DW=64, AW=10): reset, wait states, byte
// lanes, CAB bursts, burst address error, retry, error injection, address
// wrap and cycle abort. Counter expectations follow WB_MEM_STATS_EN.
// ---------------------------------------------------------------------------
module tb_wb_mem_slave;
  import wb_mem_pkg::*;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_ACK  = 2'd1;
  localparam logic [1:0] T_ERR  = 2'd2;
  localparam logic [1:0] T_RTY  = 2'd3;

`ifdef WB_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, rstN;
  logic        cyc, stb, we, cab;
  logic [31:0] adr;
  logic [7:0]  sel;
  logic [63:0] datI, datO;
  logic        ack, err, rty, busy;
  logic [3:0]  cfgWait, cfgRty;
  logic        cfgErrEn;
  logic [31:0] cfgErrAdr;
  logic [15:0] beatCnt;
  logic [7:0]  errCnt;

  int          checkCount = 0;
  int          passCount  = 0;

  logic [63:0] burstWr [4];
  logic [63:0] burstRd [4];

  wb_mem_slave dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rstN),
    .wbs_cyc_i     (cyc),
    .wbs_stb_i     (stb),
    .wbs_we_i      (we),
    .wbs_cab_i     (cab),
    .wbs_adr_i     (adr),
    .wbs_sel_i     (sel),
    .wbs_dat_i     (datI),
    .wbs_dat_o     (datO),
    .wbs_ack_o     (ack),
    .wbs_err_o     (err),
    .wbs_rty_o     (rty),
    .cfg_wait_i    (cfgWait),
    .cfg_rty_i     (cfgRty),
    .cfg_err_en_i  (cfgErrEn),
    .cfg_err_adr_i (cfgErrAdr),
    .beat_cnt_o    (beatCnt),
    .err_cnt_o     (errCnt),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Single (non-CAB) access; called and returns at a negedge.
  task automatic applyStimulus(input logic weIn, input logic [31:0] adrIn,
                               input logic [7:0] selIn, input logic [63:0] datIn,
                               input logic keepCyc, output logic [1:0] termOut,
                               output logic [63:0] rdOut, output int cyclesOut);
    bit done;
    done = 1'b0;
    termOut = T_NONE;
    rdOut = '0;
    cyclesOut = 0;
    cyc = 1'b1; stb = 1'b1; cab = 1'b0; we = weIn;
    adr = adrIn; sel = selIn; datI = datIn;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      cyclesOut++;
      if (ack)      begin termOut = T_ACK; rdOut = datO; done = 1'b1; end
      else if (err) begin termOut = T_ERR; done = 1'b1; end
      else if (rty) begin termOut = T_RTY; done = 1'b1; end
    end
    stb = 1'b0; we = 1'b0;
    if (!keepCyc) cyc = 1'b0;
    @(negedge clk);
  endtask

  // CAB burst; the master advances address/data in the cycle each ack is seen.
  task automatic burstStimulus(input logic weIn, input logic [31:0] startAdr,
                               input int n, input int badBeat, input logic [31:0] badAdr,
                               output int acks, output logic errSeen);
    bit done;
    done = 1'b0;
    acks = 0;
    errSeen = 1'b0;
    cyc = 1'b1; stb = 1'b1; cab = 1'b1; we = weIn; sel = 8'hFF;
    adr = startAdr; datI = burstWr[0];
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (ack) begin
        if (acks < 4) burstRd[acks] = datO;
        acks++;
        if (acks >= n) done = 1'b1;
        else begin
          adr  = (acks == badBeat) ? badAdr : startAdr + 32'(8 * acks);
          datI = burstWr[acks];
        end
      end else if (err) begin
        errSeen = 1'b1;
        done = 1'b1;
      end
    end
    cyc = 1'b0; stb = 1'b0; cab = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  term;
    logic [63:0] rd;
    int          ncyc;
    int          acks;
    logic        errSeen;
    logic        sawAck;

    rstN = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cab = 1'b0;
    adr = '0; sel = '0; datI = '0;
    cfgWait = '0; cfgRty = '0; cfgErrEn = 1'b0; cfgErrAdr = '0;
    burstWr[0] = 64'h1111_0000_0000_0080;
    burstWr[1] = 64'h2222_0000_0000_0081;
    burstWr[2] = 64'h3333_0000_0000_0082;
    burstWr[3] = 64'h4444_0000_0000_0083;
    for (int i = 0; i < 4; i++) burstRd[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_dat",  datO, 64'h0);
    checkOutput("rst_ack",  ack, 1'b0);
    checkOutput("rst_err",  err, 1'b0);
    checkOutput("rst_rty",  rty, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_beat", beatCnt, 16'h0);
    checkOutput("rst_errc", errCnt, 8'h0);
    rstN = 1'b1;
    @(negedge clk);

    // Single write with 3 wait states, then zero-wait read
    cfgWait = 4'd3;
    applyStimulus(1'b1, 32'h0, 8'hFF, 64'h0000_0300_0000_0200, 1'b0, term, rd, ncyc);
    checkOutput("wr_w3_term", term, T_ACK);
    checkOutput("wr_w3_lat",  ncyc, 4);
    cfgWait = 4'd0;
    applyStimulus(1'b0, 32'h0, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("rd_w0_term", term, T_ACK);
    checkOutput("rd_w0_lat",  ncyc, 1);
    checkOutput("rd_w0_data", rd, 64'h0000_0300_0000_0200);

    // Partial write of the low lanes
    applyStimulus(1'b1, 32'h0, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, term, rd, ncyc);
    applyStimulus(1'b0, 32'h0, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("partial_data", rd, 64'h0000_0300_CCCC_DDDD);
    checkOutput("beats_a", beatCnt, STATS ? 64'd4 : 64'd0);

    // Reset asserted in the middle of WAIT
    cfgWait = 4'd6;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; sel = 8'hFF; datI = 64'hDEAD_0000_0000_0008;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midwait_busy", busy, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_busy", busy, 1'b0);
    checkOutput("async_rst_ack",  ack, 1'b0);
    checkOutput("async_rst_beat", beatCnt, 16'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    cfgWait = 4'd1;
    applyStimulus(1'b1, 32'h8, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, term, rd, ncyc);
    applyStimulus(1'b0, 32'h8, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("post_rst_lat",  ncyc, 2);
    checkOutput("post_rst_data", rd, 64'h0123_4567_89AB_CDEF);

    // CAB burst write then read, 4 beats at 0x400
    cfgWait = 4'd0;
    burstStimulus(1'b1, 32'h400, 4, -1, 32'h0, acks, errSeen);
    checkOutput("bwr_acks", acks, 4);
    burstStimulus(1'b0, 32'h400, 4, -1, 32'h0, acks, errSeen);
    checkOutput("brd_acks", acks, 4);
    checkOutput("brd_err",  errSeen, 1'b0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("brd_data%0d", i), burstRd[i], burstWr[i]);
    applyStimulus(1'b0, 32'h418, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("rd_418", rd, 64'h4444_0000_0000_0083);

    // Burst with a non-linear address on the second beat
    burstStimulus(1'b0, 32'h400, 4, 1, 32'h410, acks, errSeen);
    checkOutput("bbad_acks", acks, 1);
    checkOutput("bbad_err",  errSeen, 1'b1);
    checkOutput("beats_b", beatCnt, STATS ? 64'd12 : 64'd0);
    checkOutput("errs_b",  errCnt,  STATS ? 64'd1  : 64'd0);

    // Retry: two rty then ack, and again after a new cycle
    cfgRty = 4'd2;
    applyStimulus(1'b0, 32'h400, 8'hFF, 64'h0, 1'b1, term, rd, ncyc);
    checkOutput("rty1_term", term, T_RTY);
    applyStimulus(1'b0, 32'h400, 8'hFF, 64'h0, 1'b1, term, rd, ncyc);
    checkOutput("rty2_term", term, T_RTY);
    applyStimulus(1'b0, 32'h400, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("rty3_term", term, T_ACK);
    checkOutput("rty3_data", rd, 64'h1111_0000_0000_0080);
    applyStimulus(1'b0, 32'h400, 8'hFF, 64'h0, 1'b1, term, rd, ncyc);
    checkOutput("rtyb1_term", term, T_RTY);
    applyStimulus(1'b0, 32'h400, 8'hFF, 64'h0, 1'b1, term, rd, ncyc);
    checkOutput("rtyb2_term", term, T_RTY);
    applyStimulus(1'b0, 32'h400, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("rtyb3_term", term, T_ACK);
    cfgRty = 4'd0;

    // Error injection on word 0x500
    applyStimulus(1'b1, 32'h500, 8'hFF, 64'h5555_0000_0000_0500, 1'b0, term, rd, ncyc);
    cfgErrEn = 1'b1; cfgErrAdr = 32'h500;
    applyStimulus(1'b1, 32'h500, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, term, rd, ncyc);
    checkOutput("einj_term", term, T_ERR);
    applyStimulus(1'b1, 32'h508, 8'hFF, 64'h6666_0000_0000_0508, 1'b0, term, rd, ncyc);
    checkOutput("einj_next_term", term, T_ACK);
    cfgRty = 4'd1;
    applyStimulus(1'b1, 32'h500, 8'hFF, 64'hBAD1_BAD1_BAD1_BAD1, 1'b1, term, rd, ncyc);
    checkOutput("rty_over_err", term, T_RTY);
    applyStimulus(1'b1, 32'h500, 8'hFF, 64'hBAD2_BAD2_BAD2_BAD2, 1'b0, term, rd, ncyc);
    checkOutput("err_after_rty", term, T_ERR);
    cfgRty = 4'd0; cfgErrEn = 1'b0;
    applyStimulus(1'b0, 32'h500, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("einj_ram_kept", rd, 64'h5555_0000_0000_0500);
    applyStimulus(1'b0, 32'h508, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("einj_508_data", rd, 64'h6666_0000_0000_0508);

    // Address wrap and ignored byte offset
    applyStimulus(1'b1, 32'h2000, 8'hFF, 64'h7777_8888_9999_AAAA, 1'b0, term, rd, ncyc);
    applyStimulus(1'b0, 32'h0, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("wrap_data", rd, 64'h7777_8888_9999_AAAA);
    applyStimulus(1'b0, 32'h5, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("offset_data", rd, 64'h7777_8888_9999_AAAA);

    // cyc dropped during WAIT: no ack, no write, busy clears next cycle
    applyStimulus(1'b1, 32'h10, 8'hFF, 64'hA0A0_A0A0_A0A0_A0A0, 1'b0, term, rd, ncyc);
    cfgWait = 4'd5;
    sawAck = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; sel = 8'hFF; datI = 64'hB0B0_B0B0_B0B0_B0B0;
    repeat (3) begin
      @(negedge clk);
      sawAck = sawAck | ack;
    end
    checkOutput("abort_busy_before", busy, 1'b1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    sawAck = sawAck | ack;
    checkOutput("abort_no_ack", sawAck, 1'b0);
    checkOutput("abort_busy_after", busy, 1'b0);
    cfgWait = 4'd0;
    applyStimulus(1'b0, 32'h10, 8'hFF, 64'h0, 1'b0, term, rd, ncyc);
    checkOutput("abort_no_write", rd, 64'hA0A0_A0A0_A0A0_A0A0);

    checkOutput("beats_final", beatCnt, STATS ? 64'd23 : 64'd0);
    checkOutput("errs_final",  errCnt,  STATS ? 64'd3  : 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Parametrised Wishbone slave memory responder: the memory side seen by the ADMA Wishbone master.
- Replaces the ad-hoc always-ack 64-bit memory model with a synthesisable block that has:
  - configurable data width and depth;
  - programmable wait states;
  - linear CAB burst support;
  - retry and error injection;
  - beat statistics.
- Sits on the wbm_* bus of the DMA core, in bench and FPGA bring-up builds.

Parameters:
DW, 64, data width in bits; 32 or 64.
AW, 10, log2 of depth in DW-bit words.
SW, DW/8, byte-select width (derived; not overridable).

Ports:
wb_clk_i  in  1  Wishbone clock
wb_rst_n_i  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  cycle valid
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable
wbs_cab_i  in  1  consecutive-address burst
wbs_adr_i  in  32  byte address
wbs_sel_i  in  SW  byte lane enables
wbs_dat_i  in  DW  write data
wbs_dat_o  out  DW  read data
wbs_ack_o  out  1  acknowledge
wbs_err_o  out  1  error termination
wbs_rty_o  out  1  retry termination
cfg_wait_i  in  4  wait states inserted before the first beat of each access
cfg_rty_i  in  4  number of leading attempts of each cycle answered with rty
cfg_err_en_i  in  1  enable error injection
cfg_err_adr_i  in  32  byte address whose word is answered with err
beat_cnt_o  out  16  acked beats since reset (wraps)
err_cnt_o  out  8  err terminations since reset (saturates at 255)
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, wb_rst_n_i=0): state IDLE; all outputs 0 (dat_o, ack_o, err_o, rty_o, counters, busy_o). RAM contents are not reset, and no write occurs while in reset.
- Word index = wbs_adr_i[AW+log2(SW)-1 : log2(SW)]. Higher address bits are ignored, so addresses wrap modulo depth. Low byte-offset bits are ignored.
- All terminations (ack/err/rty) are registered outputs and are mutually exclusive.
- FSM states: IDLE, WAIT, RTY, ERR, ACK.
  - IDLE: on cyc&stb, load word counter wptr = word index and wait counter = cfg_wait_i. Go to:
    - RTY, if this cycle's retry count < cfg_rty_i;
    - else ERR, if cfg_err_en_i and word index matches cfg_err_adr_i word;
    - else WAIT, if cfg_wait_i ≠ 0;
    - else ACK.
  - WAIT: decrement the wait counter. At 0, go to ACK (or ERR under the same match rule).
  - RTY: rty_o=1 for one cycle; increment the per-cycle retry count; go to IDLE.
  - ERR: err_o=1 for one cycle. No write. err_cnt_o++. Go to IDLE.
  - ACK: ack_o=1.
    - Write: RAM[wptr] updated per sel lane on the same edge ack is driven.
    - Read: dat_o = RAM[wptr], registered, valid in the ack cycle.
    - beat_cnt_o++ per beat.
    - Non-CAB: one-cycle ack, then IDLE. A minimum one idle cycle is required between single beats.
    - CAB with stb held: ack stays high every cycle with no wait states between beats; wptr increments each beat, wrapping at depth. Read data for beat n+1 is prefetched from wptr+1.
    - Burst address check: if the master's address on a continuing beat ≠ wptr+1, terminate with err instead of ack; go to ERR.
    - Burst end: stb or cab dropping ends the burst; go to IDLE.
- Latency: first beat = 1 + cfg_wait_i cycles after stb is sampled high in IDLE.
- Per-cycle retry count clears when cyc_i falls. A new cycle (cyc rising) restarts retry injection.
- cyc_i dropping in any non-IDLE state: abort to IDLE next edge, with no termination and no write.
- Simultaneous error-address match and retry pending: retry wins.
- cfg_* inputs are sampled only in IDLE at access start. Changes mid-access take effect on the next access.

Optional Feature:
- Macro WB_MEM_STATS_EN.
- Defined: beat_cnt_o and err_cnt_o count as specified.
- Undefined: both outputs are constant 0 and the counter flops are removed. All other behaviour is unchanged.

Decomposition:
- Package wb_mem_pkg:
  - state encoding (IDLE=0, WAIT, RTY, ERR, ACK);
  - default DW/AW;
  - counter widths (16, 8).
- Sub-module wb_mem_ram:
  - DW-wide, 2**AW-deep RAM with byte-lane write enables and registered read port;
  - one read/write port, address from FSM wptr mux.

Test Plan:
- Reset: hold wb_rst_n_i=0 mid-WAIT -> ack/err/rty/busy go 0 immediately. After release, a write to 0x8 then a read of 0x8 returns the written value.
- Single write/read, DW=64: write 0x0000_0300_0000_0200 to adr 0x0 with sel=0xFF, cfg_wait=3 -> ack on the 4th cycle after stb. Read back 0x…0200. A partial write with sel=0x0F changes only the low 32 bits.
- CAB burst: read 4 beats from 0x400 with linear addresses and wait=0 -> 4 consecutive acks, data = RAM[0x80..0x83], beat_cnt_o=+4. Same burst presenting 0x410 on beat 2 -> err on that beat, err_cnt_o=+1.
- Retry: cfg_rty=2 -> first two attempts get rty_o, third gets ack. Dropping cyc and restarting -> two rty again.
- Error injection: cfg_err_en=1, err_adr=0x500, write to 0x500 -> err_o one cycle, RAM unchanged. Write to 0x508 -> ack.
- Wrap/abort: AW=4, access at 0x80 aliases 0x0. cyc dropped during WAIT -> no ack, no write, busy_o returns to 0 the next cycle.
